// File: rtl/fpadd_scan_display_if.sv
// Value handshake bundle for fpadd_scan_display.
//   value       : 4*NUM_DIGITS-bit hex value, nibble k shown on digit k
//   value_valid : producer offers value this cycle
//   value_ready : display block can accept a value this cycle
// A transfer happens on a rising edge where value_valid & value_ready.
interface fpadd_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    value_valid;
  logic                    value_ready;

  modport master (
    output value,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value,
    input  value_valid,
    output value_ready
  );
endinterface

// File: rtl/fpadd_scan_display.sv
// Multiplexed seven-segment hex display driver with a tear-free update
// handshake, leading-zero blanking and blinking.
//   clk        : sole clock, all state on the rising edge
//   reset      : synchronous, active-high
//   bus        : value / value_valid / value_ready handshake (slave side)
//   blank_lz   : enables leading-zero blanking (sampled every cycle)
//   blink      : enables blinking (sampled every cycle)
//   an         : active-low digit enables, one-hot-low when a digit is lit
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   frame_tick : one-cycle pulse the cycle after each scan-frame boundary
// A new value is held in a shadow register and only copied to the displayed
// register at a frame boundary, so a scan frame never mixes two values.
module fpadd_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  fpadd_scan_display_if.slave   bus,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  frame_tick
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan timing state
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  logic                  phase_q, phase_d;
  logic                  term_cnt;
  logic                  frame_end;

  // Handshake / data state
  state_t                state_q;
  logic                  ready_q;
  logic [VAL_W-1:0]      shadow_q;
  logic [VAL_W-1:0]      disp_q;

  // Output registers
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  ft_q;

  // Combinational helpers for the output stage
  logic [3:0]            nib;
  logic                  lead_zero;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  dark;
  logic                  blank_cur;

  assign bus.value_ready = ready_q;
  assign an              = an_q;
  assign seg             = seg_q;
  assign frame_tick      = ft_q;

  // Refresh counter, digit index and blink phase.
  always_comb begin
    term_cnt  = (cnt_q == CNT_LAST);
    frame_end = term_cnt && (idx_q == IDX_LAST);

    cnt_d = term_cnt ? '0 : cnt_q + 1'b1;

    idx_d = idx_q;
    if (term_cnt) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // The phase runs whether or not blinking is enabled so that enabling
    // blink mid-stream stays aligned to the free-running frame grid.
    frm_d   = frm_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
    end
  end

  // Handshake FSM. A capture that lands on a frame boundary only fills the
  // shadow; the commit waits for the following boundary so the frame that
  // starts next is still shown entirely with the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      shadow_q <= '0;
      disp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.value_valid && ready_q) begin
            shadow_q <= bus.value;
            state_q  <= PENDING;
            ready_q  <= 1'b0;
          end
        end
        PENDING: begin
          if (frame_end) begin
            disp_q  <= shadow_q;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Digit select, leading-zero mask and blink gating.
  always_comb begin
    nib        = 4'h0;
    lead_zero  = 1'b1;
    blank_mask = '0;

    // Digit k is a leading zero when it and every more-significant nibble
    // are zero; digit 0 always stays lit so a zero value still shows "0".
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead_zero     = lead_zero && (disp_q[4*k +: 4] == 4'h0);
      blank_mask[k] = lead_zero && (k != 0);
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib = disp_q[4*k +: 4];
      end
    end

    dark      = blink && phase_q;
    blank_cur = blank_lz && blank_mask[idx_q];

    an_d = '1;
    if (!dark && !blank_cur) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = seg_decode(nib);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= 7'b1111111;
      ft_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      ft_q  <= frame_end;
    end
  end

endmodule
